// File: rtl/riscv_cache_pkg.sv
// Shared types and helpers for the data-cache miss controller.
package riscv_cache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    REFILL     = 2'd2,
    UPDATE     = 2'd3
  } cache_state_t;

  localparam int BEATS_DEFAULT = 4;

  // Beat address {tag, index, beat}, built wide and truncated by the caller
  function automatic logic [63:0] mk_mem_addr(input logic [63:0] tag,
                                              input logic [63:0] idx,
                                              input logic [63:0] bt,
                                              input int          idx_w,
                                              input int          beat_w);
    return (tag << (idx_w + beat_w)) | (idx << beat_w) | bt;
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Modulo-BEATS burst beat counter; BEATS is a power of two so it wraps naturally.
module cache_beat_counter #(
  parameter int BEATS = 4,
  localparam int BW = $clog2(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] cnt,
  output logic          last
);

  // Clear has priority over increment
  always_ff @(posedge clk or negedge rst)
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;

  assign last = (cnt == BW'(BEATS - 1));

endmodule

// File: rtl/dcache_fsm.sv
// Data-cache miss controller: drives tag_array updates and write-back/refill bursts.
module dcache_fsm
  import riscv_cache_pkg::*;
#(
  parameter int IDX   = 12,
  parameter int TAG   = 9,
  parameter int BEATS = BEATS_DEFAULT,
  localparam int BW = $clog2(BEATS),
  localparam int AW = TAG + IDX + BW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_rd,
  input  logic           cpu_wr,
  input  logic [TAG-1:0] cpu_tag,
  input  logic [IDX-1:0] cpu_index,
  input  logic           hit,
  input  logic           dirty,
  input  logic           valid_old,
  input  logic [TAG-1:0] tag_old,
  output logic           stall,
  output logic           replace_tag,
  output logic           valid_in,
  output logic           dirty_in,
  output logic           data_we,
  output logic           refill_we,
  output logic [BW-1:0]  beat,
  output logic           mem_rd_req,
  output logic           mem_wr_req,
  output logic [AW-1:0]  mem_addr,
  input  logic           mem_ack,
  output logic [31:0]    miss_count
);

  cache_state_t   state_q, state_d;
  logic           req, miss, in_idle, in_wb, in_rf, beat_last;
  logic [31:0]    miss_q;
  logic [TAG-1:0] addr_tag;

  assign req     = cpu_rd | cpu_wr;
  assign miss    = req & ~hit;
  assign in_idle = (state_q == IDLE);
  assign in_wb   = (state_q == WRITE_BACK);
  assign in_rf   = (state_q == REFILL);

  cache_beat_counter #(.BEATS(BEATS)) u_beat (
    .clk  (clk),
    .rst  (rst),
    .clr  (in_idle & miss),
    .inc  ((in_wb | in_rf) & mem_ack),
    .cnt  (beat),
    .last (beat_last)
  );

  // Next-state decode; mem_ack only matters inside a burst
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (miss) state_d = (valid_old & dirty) ? WRITE_BACK : REFILL;
      WRITE_BACK: if (mem_ack & beat_last) state_d = REFILL;
      REFILL:     if (mem_ack & beat_last) state_d = UPDATE;
      UPDATE:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State register; reset aborts any burst without touching tag state
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;

  // Saturating miss counter, bumped on the IDLE cycle that detects the miss
  always_ff @(posedge clk or negedge rst)
    if (!rst)                              miss_q <= '0;
    else if (in_idle & miss & ~(&miss_q))  miss_q <= miss_q + 32'd1;

  assign miss_count = miss_q;

  // Combinational strobes; replace_tag only changes on a rising edge since
  // it depends on registered state and core inputs held stable while stalled
  assign stall       = ~in_idle | miss;
  assign data_we     = in_idle & cpu_wr & hit;
  assign replace_tag = data_we | (state_q == UPDATE);
  assign valid_in    = replace_tag;
  assign dirty_in    = data_we;
  assign refill_we   = in_rf & mem_ack;
  assign mem_wr_req  = in_wb;
  assign mem_rd_req  = in_rf;

  assign addr_tag = in_wb ? tag_old : cpu_tag;
  assign mem_addr = (in_wb | in_rf)
                  ? AW'(mk_mem_addr(64'(addr_tag), 64'(cpu_index), 64'(beat), IDX, BW))
                  : '0;

endmodule

// File: tb/tb_dcache_fsm.sv
// Self-checking bench for dcache_fsm: tag_array and memory environment plus a
// line-level reference model of hit/miss, burst contents and stall length.
module tb_dcache_fsm;
  localparam int IDX = 12, TAG = 9, BEATS = 4, BW = 2, AW = TAG + IDX + BW;

  logic clk = 0, rst = 0;
  logic cpu_rd = 0, cpu_wr = 0, mem_ack = 0;
  logic [TAG-1:0] cpu_tag = '0, tag_old;
  logic [IDX-1:0] cpu_index = '0;
  logic hit, dirty, valid_old;
  logic stall, replace_tag, valid_in, dirty_in, data_we, refill_we, mem_rd_req, mem_wr_req;
  logic [BW-1:0] beat;
  logic [AW-1:0] mem_addr;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  dcache_fsm #(.IDX(IDX), .TAG(TAG), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_tag(cpu_tag),
    .cpu_index(cpu_index), .hit(hit), .dirty(dirty), .valid_old(valid_old),
    .tag_old(tag_old), .stall(stall), .replace_tag(replace_tag), .valid_in(valid_in),
    .dirty_in(dirty_in), .data_we(data_we), .refill_we(refill_we), .beat(beat),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .miss_count(miss_count)
  );

  // tag_array environment: written on the falling edge from the DUT's controls
  logic [TAG-1:0] env_t [0:(1<<IDX)-1];
  logic           env_v [0:(1<<IDX)-1];
  logic           env_d [0:(1<<IDX)-1];
  assign hit       = env_v[cpu_index] && (env_t[cpu_index] == cpu_tag);
  assign dirty     = env_d[cpu_index];
  assign valid_old = env_v[cpu_index];
  assign tag_old   = env_t[cpu_index];
  always @(negedge clk)
    if (replace_tag) begin
      env_t[cpu_index] <= cpu_tag;
      env_v[cpu_index] <= valid_in;
      env_d[cpu_index] <= dirty_in;
    end

  // Reference model: line contents and miss counter
  logic [TAG-1:0] ref_t [0:(1<<IDX)-1];
  bit             ref_v [0:(1<<IDX)-1];
  bit             ref_d [0:(1<<IDX)-1];
  logic [31:0]    ref_mc = 0;

  typedef struct { bit wr; logic [AW-1:0] a; } ev_t;
  ev_t exq[$];

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One core access held until it completes; memory acks after d wait cycles
  task automatic access(input bit rd, input bit wr, input logic [TAG-1:0] tg,
                        input logic [IDX-1:0] ix, input int d);
    bit miss, wb;
    int exp_st, st, wc, upd;
    ev_t e;
    miss = !(ref_v[ix] && ref_t[ix] == tg);
    wb   = miss && ref_v[ix] && ref_d[ix];
    exq.delete();
    if (wb)   for (int b = 0; b < BEATS; b++) exq.push_back('{1'b1, {ref_t[ix], ix, BW'(b)}});
    if (miss) for (int b = 0; b < BEATS; b++) exq.push_back('{1'b0, {tg, ix, BW'(b)}});
    exp_st = miss ? 2 + (wb ? 2 : 1) * BEATS * (d + 1) : 0;
    if (miss && ref_mc != 32'hFFFF_FFFF) ref_mc++;
    st = 0; wc = 0; upd = 0;
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_tag = tg; cpu_index = ix; mem_ack = 0;
    for (int cyc = 0; ; cyc++) begin
      if (cyc > 300) begin chk("timeout", 1, 0); break; end
      if (mem_rd_req | mem_wr_req) begin
        if (wc == d) begin mem_ack = 1; wc = 0; end
        else begin mem_ack = 0; wc++; end
      end else mem_ack = 0;
      #3;
      if (!stall) break;
      st++;
      if (mem_rd_req | mem_wr_req) begin
        e = (exq.size() != 0) ? exq[0] : '{1'b0, '0};
        chk("mem_is_write", mem_wr_req, e.wr);
        chk("mem_addr", mem_addr, e.a);
        chk("refill_we", refill_we, mem_ack & mem_rd_req);
        if (mem_ack && exq.size() != 0) void'(exq.pop_front());
      end
      if (replace_tag) begin
        upd++;
        chk("update_dirty_in", dirty_in, 0);
        chk("update_valid_in", valid_in, 1);
      end
      @(posedge clk); #1;
    end
    mem_ack = 0;
    chk("stall_cycles", st, exp_st);
    chk("beats_left", exq.size(), 0);
    chk("update_pulses", upd, miss);
    chk("miss_count", miss_count, ref_mc);
    chk("hit_data_we", data_we, wr);
    chk("hit_replace_tag", replace_tag, wr);
    chk("hit_dirty_in", dirty_in, wr);
    ref_v[ix] = 1; ref_t[ix] = tg;
    ref_d[ix] = wr ? 1'b1 : (miss ? 1'b0 : ref_d[ix]);
    @(posedge clk); #1;
    cpu_rd = 0; cpu_wr = 0;
  endtask

  // Idle with a random address and a stray ack: nothing may move
  task automatic idle_check();
    cpu_tag = TAG'($urandom); cpu_index = IDX'($urandom); mem_ack = 1;
    #1;
    chk("idle_out", {stall, replace_tag, valid_in, dirty_in, data_we, refill_we,
                     mem_rd_req, mem_wr_req, mem_addr, beat}, 0);
    @(posedge clk); #1;
    chk("idle_beat_after_ack", beat, 0);
    mem_ack = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << IDX); i++) begin
      env_t[i] = '0; env_v[i] = 0; env_d[i] = 0;
      ref_t[i] = '0; ref_v[i] = 0; ref_d[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {stall, replace_tag, valid_in, dirty_in, data_we, refill_we,
                      mem_rd_req, mem_wr_req, mem_addr, beat}, 0);
    chk("reset_miss_count", miss_count, 0);
    rst = 1;
    idle_check();

    access(1, 0, 9'h1A, 12'd5, 0);   // clean miss
    access(0, 1, 9'h1A, 12'd5, 0);   // write hit dirties line
    access(1, 0, 9'h0B, 12'd5, 0);   // dirty miss: write-back then refill
    access(1, 0, 9'h0C, 12'd6, 3);   // slow memory
    access(0, 1, 9'h0C, 12'd6, 3);
    access(1, 1, 9'h0D, 12'd6, 2);   // rd+wr acts as store, dirty miss
    idle_check();

    // Reset in the middle of refill beat 2
    @(posedge clk); #1;
    cpu_rd = 1; cpu_tag = 9'h33; cpu_index = 12'd9;
    for (int cyc = 0; cyc < 60; cyc++) begin
      mem_ack = mem_rd_req;
      #3;
      if (mem_rd_req && beat == 2) break;
      @(posedge clk); #1;
    end
    chk("reached_refill_beat2", {mem_rd_req, beat}, {1'b1, 2'd2});
    mem_ack = 0;
    #1 rst = 0;
    #1;
    chk("rst_reqs", {mem_rd_req, mem_wr_req, refill_we, replace_tag, beat}, 0);
    chk("rst_miss_count", miss_count, 0);
    cpu_rd = 0;
    #1 chk("rst_stall", stall, 0);
    @(posedge clk); #1 rst = 1;
    ref_mc = 0;
    access(1, 0, 9'h33, 12'd9, 0);   // line never validated: misses again

    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, TAG'($urandom_range(0, 3)), IDX'($urandom_range(0, 3)),
             $urandom_range(0, 2));
    end

    // Saturation
    @(posedge clk); #1;
    force dut.miss_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.miss_q;
    #1 chk("sat_preload", miss_count, 32'hFFFF_FFFF);
    ref_mc = 32'hFFFF_FFFF;
    access(1, 0, 9'h77, 12'd100, 0);
    access(0, 1, 9'h55, 12'd101, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
